// File: rtl/tick_gen.sv
// Two-stage prescaler producing millisecond and second strobes, plus a
// loadable seconds countdown that strobes when it expires.
module tick_gen #(
  parameter int MS_DIV   = 125000,
  parameter int S_DIV    = 1000,
  parameter int FAST_DIV = 10,
  parameter int CD_W     = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            clr,
  input  logic            fast,
  input  logic            cd_load,
  input  logic [CD_W-1:0] cd_val,
  output logic            tick_ms,
  output logic            tick_s,
  output logic [CD_W-1:0] cd_cnt,
  output logic            cd_done
);

  localparam int B_MAX = (S_DIV > FAST_DIV) ? S_DIV : FAST_DIV;
  localparam int A_W   = (MS_DIV > 2) ? $clog2(MS_DIV) : 1;
  localparam int B_W   = (B_MAX > 2) ? $clog2(B_MAX) : 1;

  localparam logic [A_W-1:0]  A_LAST = A_W'(MS_DIV - 1);
  localparam logic [A_W-1:0]  A_ONE  = A_W'(1);
  localparam logic [B_W-1:0]  S_LAST = B_W'(S_DIV - 1);
  localparam logic [B_W-1:0]  F_LAST = B_W'(FAST_DIV - 1);
  localparam logic [B_W-1:0]  B_ONE  = B_W'(1);
  localparam logic [CD_W-1:0] CD_ONE = CD_W'(1);

  logic [A_W-1:0] cnt_a;
  logic [B_W-1:0] cnt_b;
  logic [B_W-1:0] lim_last;
  logic           wrap_a;
  logic           wrap_b;

  // The >= lets a mid-count switch to a shorter second wrap on the next ms tick.
  always_comb begin
    lim_last = fast ? F_LAST : S_LAST;
    wrap_a   = en && (cnt_a == A_LAST);
    wrap_b   = wrap_a && (cnt_b >= lim_last);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_a   <= '0;
      cnt_b   <= '0;
      tick_ms <= 1'b0;
      tick_s  <= 1'b0;
    end else if (clr) begin
      cnt_a   <= '0;
      cnt_b   <= '0;
      tick_ms <= 1'b0;
      tick_s  <= 1'b0;
    end else begin
      tick_ms <= wrap_a;
      tick_s  <= wrap_b;
      if (en) begin
        cnt_a <= wrap_a ? '0 : cnt_a + A_ONE;
      end
      if (wrap_a) begin
        cnt_b <= wrap_b ? '0 : cnt_b + B_ONE;
      end
    end
  end

  // A load wins over a same-cycle decrement; zero is an idle state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cd_cnt  <= '0;
      cd_done <= 1'b0;
    end else if (cd_load) begin
      cd_cnt  <= cd_val;
      cd_done <= 1'b0;
    end else if (wrap_b && (cd_cnt != '0)) begin
      cd_cnt  <= cd_cnt - CD_ONE;
      cd_done <= (cd_cnt == CD_ONE);
    end else begin
      cd_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tick_gen.sv
// Directed bench for tick_gen with a cycle model of the prescaler and
// countdown rules compared against the DUT on every falling edge.
module tb_tick_gen;

  localparam int MS_DIV   = 4;
  localparam int S_DIV    = 3;
  localparam int FAST_DIV = 2;
  localparam int CD_W     = 4;

  logic            clk     = 1'b0;
  logic            rst     = 1'b1;
  logic            en      = 1'b0;
  logic            clr     = 1'b0;
  logic            fast    = 1'b0;
  logic            cd_load = 1'b0;
  logic [CD_W-1:0] cd_val  = '0;
  logic            tick_ms;
  logic            tick_s;
  logic [CD_W-1:0] cd_cnt;
  logic            cd_done;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit check_on  = 1'b0;

  int m_edges   = 0;
  int m_ms_cnt  = 0;
  int m_cd      = 0;
  bit m_ms      = 1'b0;
  bit m_s       = 1'b0;
  bit m_done    = 1'b0;
  bit m_wa;
  bit m_wb;
  int m_lim;

  tick_gen #(
    .MS_DIV  (MS_DIV),
    .S_DIV   (S_DIV),
    .FAST_DIV(FAST_DIV),
    .CD_W    (CD_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .clr    (clr),
    .fast   (fast),
    .cd_load(cd_load),
    .cd_val (cd_val),
    .tick_ms(tick_ms),
    .tick_s (tick_s),
    .cd_cnt (cd_cnt),
    .cd_done(cd_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input bit e, input bit c, input bit f, input bit l,
                               input logic [CD_W-1:0] v);
    en      = e;
    clr     = c;
    fast    = f;
    cd_load = l;
    cd_val  = v;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic waitTick(input bit on_s, input int bound, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (n < bound && !(on_s ? tick_s : tick_ms));
  endtask

  // Model: enabled edges since clear, ms ticks within the current second,
  // and the seconds left on the countdown.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_edges  = 0;
      m_ms_cnt = 0;
      m_cd     = 0;
      m_ms     = 1'b0;
      m_s      = 1'b0;
      m_done   = 1'b0;
    end else begin
      m_lim = fast ? FAST_DIV : S_DIV;
      m_wa  = en && ((m_edges + 1) % MS_DIV == 0);
      m_wb  = m_wa && (m_ms_cnt + 1 >= m_lim);
      if (cd_load) begin
        m_cd   = int'(cd_val);
        m_done = 1'b0;
      end else if (m_wb && m_cd > 0) begin
        m_cd   = m_cd - 1;
        m_done = (m_cd == 0);
      end else begin
        m_done = 1'b0;
      end
      if (clr) begin
        m_edges  = 0;
        m_ms_cnt = 0;
        m_ms     = 1'b0;
        m_s      = 1'b0;
      end else begin
        m_ms = m_wa;
        m_s  = m_wb;
        if (en) m_edges = (m_edges + 1) % MS_DIV;
        if (m_wb) m_ms_cnt = 0;
        else if (m_wa) m_ms_cnt = m_ms_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (check_on && !rst) begin
      checkOutput("model_tick_ms", int'(tick_ms), int'(m_ms));
      checkOutput("model_tick_s",  int'(tick_s),  int'(m_s));
      checkOutput("model_cd_cnt",  int'(cd_cnt),  m_cd);
      checkOutput("model_cd_done", int'(cd_done), int'(m_done));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int m;
    repeat (2) @(negedge clk);
    checkOutput("rst_tick_ms", int'(tick_ms), 0);
    checkOutput("rst_tick_s",  int'(tick_s),  0);
    checkOutput("rst_cd_cnt",  int'(cd_cnt),  0);
    checkOutput("rst_cd_done", int'(cd_done), 0);

    rst = 1'b0;
    applyStimulus(1, 0, 0, 0, 0);
    check_on = 1'b1;

    for (int k = 1; k <= 30; k++) begin
      step();
      checkOutput("free_tick_ms", int'(tick_ms), int'(k % 4 == 0));
      checkOutput("free_tick_s",  int'(tick_s),  int'(k == 12 || k == 24));
    end

    applyStimulus(0, 0, 0, 0, 0);
    n = 0;
    repeat (5) begin
      step();
      n++;
      checkOutput("gated_tick_ms", int'(tick_ms), 0);
    end
    applyStimulus(1, 0, 0, 0, 0);
    waitTick(1'b0, 20, m);
    checkOutput("gate_delay", n + m, 7);

    repeat (3) step();
    applyStimulus(1, 1, 0, 0, 0);
    step();
    checkOutput("clr_no_tick", int'(tick_ms), 0);
    applyStimulus(1, 0, 0, 0, 0);
    waitTick(1'b0, 20, n);
    checkOutput("clr_restart", n, 4);

    repeat (4) step();
    checkOutput("pre_fast_ms", int'(tick_ms), 1);
    checkOutput("pre_fast_s",  int'(tick_s),  0);
    applyStimulus(1, 0, 1, 0, 0);
    waitTick(1'b1, 20, n);
    checkOutput("fast_first_s", n, 4);
    for (int k = 1; k <= 16; k++) begin
      step();
      checkOutput("fast_tick_s", int'(tick_s), int'(k % 8 == 0));
    end

    applyStimulus(1, 0, 1, 1, 3);
    step();
    applyStimulus(1, 0, 1, 0, 0);
    checkOutput("cd_loaded", int'(cd_cnt), 3);
    waitTick(1'b1, 20, n);
    checkOutput("cd_gap1", n, 7);
    checkOutput("cd_step2", int'(cd_cnt), 2);
    checkOutput("cd_done2", int'(cd_done), 0);
    waitTick(1'b1, 20, n);
    checkOutput("cd_gap2", n, 8);
    checkOutput("cd_step1", int'(cd_cnt), 1);
    checkOutput("cd_done1", int'(cd_done), 0);
    waitTick(1'b1, 20, n);
    checkOutput("cd_gap3", n, 8);
    checkOutput("cd_step0", int'(cd_cnt), 0);
    checkOutput("cd_done0", int'(cd_done), 1);
    for (int k = 1; k <= 20; k++) begin
      step();
      checkOutput("cd_idle_done", int'(cd_done), 0);
      checkOutput("cd_idle_cnt",  int'(cd_cnt),  0);
    end
    waitTick(1'b1, 20, n);
    checkOutput("cd_idle_gap", n, 4);

    applyStimulus(1, 0, 1, 1, 2);
    step();
    applyStimulus(1, 0, 1, 0, 0);
    checkOutput("pre_coinc_cnt", int'(cd_cnt), 2);
    repeat (6) step();
    applyStimulus(1, 0, 1, 1, 5);
    step();
    applyStimulus(1, 0, 1, 0, 0);
    checkOutput("coinc_tick_s", int'(tick_s), 1);
    checkOutput("coinc_cd_cnt", int'(cd_cnt), 5);
    checkOutput("coinc_cd_done", int'(cd_done), 0);

    applyStimulus(1, 0, 1, 1, 0);
    step();
    applyStimulus(1, 0, 1, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      step();
      checkOutput("zero_load_done", int'(cd_done), 0);
    end
    checkOutput("zero_load_cnt", int'(cd_cnt), 0);

    applyStimulus(1, 0, 1, 1, 3);
    step();
    applyStimulus(1, 0, 1, 0, 0);
    waitTick(1'b1, 20, n);
    checkOutput("pre_rst_cnt", int'(cd_cnt), 2);
    step();
    #3 rst = 1'b1;
    #1;
    checkOutput("async_tick_ms", int'(tick_ms), 0);
    checkOutput("async_tick_s",  int'(tick_s),  0);
    checkOutput("async_cd_cnt",  int'(cd_cnt),  0);
    checkOutput("async_cd_done", int'(cd_done), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    waitTick(1'b0, 20, n);
    checkOutput("post_rst_first_ms", n, 4);

    $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/tick_gen.md
# tick_gen

Parametrised two-stage tick generator with a built-in seconds countdown, for the traffic-light controller and later timing-driven blocks. A runtime-selectable prescaler chain derives single-cycle millisecond and second strobes from the system clock. A fast mode shortens the second for demo and simulation. A loadable down-counter times light phases in whole seconds and strobes on expiry.

## Interface
- MS_DIV, 125000: clk cycles per tick_ms; must be ≥ 2.
- S_DIV, 1000: tick_ms events per tick_s in normal mode; must be ≥ 1.
- FAST_DIV, 10: tick_ms events per tick_s when fast = 1; must be ≥ 1.
- CD_W, 8: countdown width.
- Derived widths: A_W = $clog2(MS_DIV), B_W = $clog2(max(S_DIV, FAST_DIV)); each is at least 1.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  prescaler count enable; when low, counters hold.
- clr  in  1  synchronous prescaler clear; has priority over en.
- fast  in  1  selects FAST_DIV instead of S_DIV for stage B.
- cd_load  in  1  loads the countdown from cd_val.
- cd_val  in  CD_W  countdown load value, in seconds.
- tick_ms  out  1  one-cycle strobe per stage-A wrap.
- tick_s  out  1  one-cycle strobe per stage-B wrap.
- cd_cnt  out  CD_W  current countdown value.
- cd_done  out  1  one-cycle strobe when cd_cnt reaches 0 by counting.

## Operation
- Stage A: cnt_a counts 0..MS_DIV-1 on each clk while en = 1. wrap_a = en & (cnt_a == MS_DIV-1). On wrap_a, cnt_a returns to 0.
- Stage B: lim_b = fast ? FAST_DIV : S_DIV. cnt_b advances only on wrap_a.
- wrap_b = wrap_a & (cnt_b ≥ lim_b-1). On wrap_b, cnt_b returns to 0. The ≥ comparison covers a mid-count switch to a smaller limit: the next wrap_a fires wrap_b immediately.
- Outputs are registered: tick_ms <= wrap_a and tick_s <= wrap_b. tick_s therefore always coincides with a tick_ms.
- en = 0: cnt_a and cnt_b hold; tick_ms and tick_s are 0 on the next cycle.
- clr = 1: cnt_a and cnt_b go to 0, tick_ms and tick_s go to 0 next cycle, regardless of en. clr does not affect the countdown.
- Countdown, in priority order:
  - cd_load: cd_cnt <= cd_val and cd_done <= 0. A load in the same cycle as wrap_b suppresses the decrement.
  - else wrap_b & (cd_cnt != 0): cd_cnt decrements, and cd_done <= (cd_cnt == 1).
  - else: cd_cnt holds and cd_done <= 0.
- cd_cnt = 0 is idle: no further decrement and no further cd_done.
- Loading 0 never produces cd_done.
- cd_done coincides with the tick_s that brought cd_cnt to 0.

## Timing
- Reset values: cnt_a = 0, cnt_b = 0, tick_ms = 0, tick_s = 0, cd_cnt = 0, cd_done = 0.
- Reset applies asynchronously and can occur mid-count; counting restarts from 0 after release.
- With en held high from reset release, edges are counted as enabled edges: tick_ms goes high after the MS_DIV-th edge, then recurs every MS_DIV cycles.
- First tick_s occurs after MS_DIV·lim_b enabled edges.
- tick_ms and tick_s have 1-cycle latency from the wrap condition.
- cd_cnt changes on the same edge that raises tick_s.
- fast takes effect on the next wrap_a evaluation. It needs no synchronisation relative to clk beyond being a registered input.
- Strobes are exactly one cycle wide. With S_DIV = 1, tick_s equals tick_ms.

## Test plan
Bench parameters: MS_DIV = 4, S_DIV = 3, FAST_DIV = 2, CD_W = 4.
- Free run: rst pulse, then en = 1 for 30 cycles -> tick_ms high at cycles 4, 8, 12, …; tick_s high at cycles 12 and 24 only; every strobe is exactly 1 cycle wide.
- Enable gating and clear: drop en for 5 cycles at cnt_a = 2 -> next tick_ms is delayed by exactly 5 cycles. Assert clr together with en = 1 at cnt_a = 3 -> no tick_ms; the next tick_ms comes 4 cycles after clr deasserts.
- Fast switch: set fast = 1 while cnt_b = 2 -> tick_s on the next tick_ms; after that, tick_s on every 2nd tick_ms (every 8 cycles).
- Countdown: load cd_val = 3 -> cd_cnt steps 3, 2, 1, 0 on successive tick_s; cd_done is high only with the tick_s that produced 0; cd_cnt stays 0 with no further cd_done.
- Countdown edge cases: cd_load with cd_val = 5 in the same cycle as wrap_b -> cd_cnt = 5, no decrement, cd_done = 0. Load cd_val = 0 -> cd_done is never asserted.
- Async reset mid-countdown: assert rst at cd_cnt = 2 with cnt_a = 1 -> all outputs are 0 within the same cycle; after release, the first tick_ms comes 4 enabled edges later.
